// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the main-memory responder.
// Holds bus widths, default latency/depth and the delay-line slot state.
package mem_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int LATENCY     = 4;
    localparam int MEM_WORDS   = 1024;
    localparam int BLOCK_WORDS = 8;
    localparam int WORD_BYTES  = 2;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_VALID = 1'b1
    } slot_e;

endpackage

// File: rtl/main_mem_responder_if.sv
// main_mem_responder_if: request/response bundle between a requester
// (master) and the main-memory responder (slave).
// Signals: enable, wr, addr, data_in (request); data_out, data_valid,
// busy (response); data_addr only when MEM_ADDR_ECHO_EN is defined.
interface main_mem_responder_if #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
);

    logic              enable;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              busy;
`ifdef MEM_ADDR_ECHO_EN
    logic [ADDR_W-1:0] data_addr;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, busy, data_addr
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, busy, data_addr
    );
`else
    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, busy
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, busy
    );
`endif

endinterface

// File: rtl/resp_delay_line.sv
// resp_delay_line: fixed-length shift register of {state, payload} slots.
// Ports: clk, rst_n (async clear), in_valid/in_data (issue slot),
// out_valid/out_data (response slot), any_valid (OR of all slot states).
module resp_delay_line #(
    parameter int LATENCY = mem_pkg::LATENCY,
    parameter int W       = mem_pkg::DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         any_valid
);

    import mem_pkg::*;

    // Slot 0 is loaded at the issue edge; slot LATENCY is the response
    // cycle, so a read is visible exactly LATENCY edges after issue.
    slot_e        state [LATENCY+1];
    logic [W-1:0] data  [LATENCY+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= LATENCY; i++) begin
                state[i] <= SLOT_EMPTY;
                data[i]  <= '0;
            end
        end else begin
            state[0] <= in_valid ? SLOT_VALID : SLOT_EMPTY;
            data[0]  <= in_data;
            for (int i = 1; i <= LATENCY; i++) begin
                state[i] <= state[i-1];
                data[i]  <= data[i-1];
            end
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i <= LATENCY; i++) begin
            any_valid = any_valid | (state[i] == SLOT_VALID);
        end
    end

    assign out_valid = (state[LATENCY] == SLOT_VALID);
    assign out_data  = data[LATENCY];

endmodule

// File: rtl/main_mem_responder.sv
// main_mem_responder: pipelined word memory, one read/write per cycle,
// read data returned LATENCY cycles after issue with a one-cycle
// data_valid pulse. Ports: clk, rst_n (async, active-low), bus (slave).
// Optional MEM_ADDR_ECHO_EN: echo the issue address on bus.data_addr.
module main_mem_responder #(
    parameter int ADDR_W    = mem_pkg::ADDR_W,
    parameter int DATA_W    = mem_pkg::DATA_W,
    parameter int LATENCY   = mem_pkg::LATENCY,
    parameter int MEM_WORDS = mem_pkg::MEM_WORDS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    main_mem_responder_if.slave  bus
);

    import mem_pkg::*;

    localparam int IDX_W = $clog2(MEM_WORDS);
`ifdef MEM_ADDR_ECHO_EN
    localparam int PAY_W = DATA_W + ADDR_W;
`else
    localparam int PAY_W = DATA_W;
`endif

    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic [IDX_W-1:0]  idx;
    logic              wr_req;
    logic              rd_req;
    logic [PAY_W-1:0]  pay_in;
    logic [PAY_W-1:0]  pay_out;
    logic              out_valid;
    logic              any_valid;

    // Upper address bits wrap; bit 0 selects a byte within the word.
    assign idx    = bus.addr[IDX_W:1];
    assign wr_req = bus.enable & bus.wr;
    assign rd_req = bus.enable & ~bus.wr;

    // Array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_req) begin
            mem[idx] <= bus.data_in;
        end
    end

`ifdef MEM_ADDR_ECHO_EN
    logic unused_addr;
    assign unused_addr   = bus.addr[0];
    assign pay_in        = {bus.addr[ADDR_W-1:1], 1'b0, mem[idx]};
    assign bus.data_addr = out_valid ? pay_out[PAY_W-1:DATA_W] : '0;
`else
    logic unused_addr;
    assign unused_addr = ^{bus.addr[0], bus.addr[ADDR_W-1:IDX_W+1]};
    assign pay_in      = mem[idx];
`endif

    resp_delay_line #(
        .LATENCY (LATENCY),
        .W       (PAY_W)
    ) u_dly (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_req),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_data  (pay_out),
        .any_valid (any_valid)
    );

    assign bus.data_valid = out_valid;
    assign bus.data_out   = out_valid ? pay_out[DATA_W-1:0] : '0;
    assign bus.busy       = any_valid;

endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: table-driven bench with a response scoreboard
// plus hand-written reset-during-burst sequence.
`timescale 1ns/1ps
module tb_main_mem_responder;

    localparam int LAT   = 4;
    localparam int WORDS = 1024;

    typedef enum logic [1:0] {OP_IDLE, OP_WR, OP_RD} op_e;

    typedef struct {
        op_e         op;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [15:0] addr;
        int          due;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mon_en = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    vec_t vecs[$];
    sb_t  sb[$];
    sb_t  item;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    main_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus();

    main_mem_responder #(
        .ADDR_W(16), .DATA_W(16), .LATENCY(LAT), .MEM_WORDS(WORDS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(op_e op, logic [15:0] a,
                                logic [15:0] d, logic [15:0] e);
        vec_t v;
        v.op = op; v.addr = a; v.din = d; v.exp = e;
        return v;
    endfunction

    // Drive one request for the next rising edge; reads with push=1
    // register their expected word and arrival cycle on the scoreboard.
    task automatic issue(vec_t v, bit push);
        sb_t s;
        bus.enable  = (v.op != OP_IDLE);
        bus.wr      = (v.op == OP_WR);
        bus.addr    = v.addr;
        bus.data_in = v.din;
        if (push && v.op == OP_RD) begin
            s.data = v.exp;
            s.addr = v.addr & 16'hFFFE;
            s.due  = cyc + 1 + LAT;
            sb.push_back(s);
        end
        @(negedge clk);
        bus.enable = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clk);
        check("drain scoreboard", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.data_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected data_valid", 32'd1, 32'd0);
                end else begin
                    item = sb.pop_front();
                    check("read data", 32'(bus.data_out), 32'(item.data));
                    check("read latency", 32'(cyc), 32'(item.due));
                    check("busy with valid", 32'(bus.busy), 32'd1);
`ifdef MEM_ADDR_ECHO_EN
                    check("echo addr", 32'(bus.data_addr), 32'(item.addr));
`endif
                end
            end else begin
                check("data_out idle zero", 32'(bus.data_out), 32'd0);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    check("missing data_valid", 32'd0, 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        bus.enable  = 1'b0;
        bus.wr      = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;

        repeat (2) @(negedge clk);
        check("reset data_valid", 32'(bus.data_valid), 32'd0);
        check("reset data_out", 32'(bus.data_out), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
`ifdef MEM_ADDR_ECHO_EN
        check("reset data_addr", 32'(bus.data_addr), 32'd0);
`endif
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        vecs.push_back(mk(OP_WR, 16'h0010, 16'hBEEF, 16'h0));
        vecs.push_back(mk(OP_RD, 16'h0010, 16'h0, 16'hBEEF));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(OP_WR, 16'(16'h0100 + 2 * i),
                              16'(16'h1000 + i), 16'h0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(OP_RD, 16'(16'h0100 + 2 * i),
                              16'h0, 16'(16'h1000 + i)));
        vecs.push_back(mk(OP_WR, 16'h0020, 16'h1111, 16'h0));
        vecs.push_back(mk(OP_IDLE, 16'h0, 16'h0, 16'h0));
        vecs.push_back(mk(OP_RD, 16'h0020, 16'h0, 16'h1111));
        vecs.push_back(mk(OP_WR, 16'h0020, 16'h2222, 16'h0));
        vecs.push_back(mk(OP_RD, 16'h0020, 16'h0, 16'h2222));
        vecs.push_back(mk(OP_WR, 16'h0806, 16'h5A5A, 16'h0));
        vecs.push_back(mk(OP_RD, 16'h0006, 16'h0, 16'h5A5A));
        vecs.push_back(mk(OP_WR, 16'h0002, 16'h7777, 16'h0));
        vecs.push_back(mk(OP_RD, 16'h0802, 16'h0, 16'h7777));
        vecs.push_back(mk(OP_WR, 16'h0012, 16'h1234, 16'h0));
        vecs.push_back(mk(OP_RD, 16'h0013, 16'h0, 16'h1234));
        vecs.push_back(mk(OP_RD, 16'h0011, 16'h0, 16'hBEEF));
        vecs.push_back(mk(OP_IDLE, 16'h0, 16'h0, 16'h0));
        vecs.push_back(mk(OP_IDLE, 16'h0, 16'h0, 16'h0));
        vecs.push_back(mk(OP_RD, 16'h0100, 16'h0, 16'h1000));

        for (int i = 0; i < vecs.size(); i++) issue(vecs[i], 1'b1);
        drain();
        repeat (3) @(negedge clk);
        check("busy idle after drain", 32'(bus.busy), 32'd0);

        // Reset in the middle of a burst: nothing may come back.
        for (int i = 0; i < 3; i++)
            issue(mk(OP_RD, 16'h0010, 16'h0, 16'hBEEF), 1'b0);
        check("busy during burst", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("busy cleared by reset", 32'(bus.busy), 32'd0);
        check("valid cleared by reset", 32'(bus.data_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 4; k++) begin
            check("no stale data_valid", 32'(bus.data_valid), 32'd0);
            @(negedge clk);
        end
        issue(mk(OP_RD, 16'h0010, 16'h0, 16'hBEEF), 1'b1);
        check("busy after new read", 32'(bus.busy), 32'd1);
        drain();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
